// File: rtl/tlb_match_array_pkg.sv
// Shared definitions for the 16-entry TLB match array: entry layout, page sizes, INVTLB ops.
package tlb_match_array_pkg;

  localparam int unsigned TLBNUM  = 16;
  localparam int unsigned TLBIDXW = 4;

  // Packed entry layout, MSB first:
  // {e, vppn, ps, g, asid, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1}
  localparam int unsigned ENTRY_W   = 89;
  localparam int unsigned E_BIT     = 88;
  localparam int unsigned VPPN_LSB  = 69;
  localparam int unsigned VPPN_W    = 19;
  localparam int unsigned PS_LSB    = 63;
  localparam int unsigned PS_W      = 6;
  localparam int unsigned G_BIT     = 62;
  localparam int unsigned ASID_LSB  = 52;
  localparam int unsigned ASID_W    = 10;
  localparam int unsigned PAGE_W    = 26;
  localparam int unsigned PAGE0_LSB = 26;
  localparam int unsigned PAGE1_LSB = 0;
  // Search key is the top slice of the entry (e down to asid).
  localparam int unsigned KEY_W     = 37;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_2M = 6'd21;

  localparam logic [4:0] INV_ALL0      = 5'd0;
  localparam logic [4:0] INV_ALL1      = 5'd1;
  localparam logic [4:0] INV_GLB       = 5'd2;
  localparam logic [4:0] INV_NGLB      = 5'd3;
  localparam logic [4:0] INV_ASID      = 5'd4;
  localparam logic [4:0] INV_ASID_VA   = 5'd5;
  localparam logic [4:0] INV_G_ASID_VA = 5'd6;

  typedef struct packed {
    logic              e;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]   ps;
    logic              g;
    logic [ASID_W-1:0] asid;
  } tlb_key_t;

  // Only 2MB pages compare the short VPPN; everything else is treated as 4KB.
  function automatic logic is_2m(input logic [PS_W-1:0] ps);
    return ps == PS_2M;
  endfunction

endpackage

// File: rtl/tlb_entry_cmp.sv
// Per-entry comparator: search hit, odd-page select and INVTLB selection for one TLB entry.
module tlb_entry_cmp
  import tlb_match_array_pkg::*;
(
  input  tlb_key_t          key,
  input  logic [VPPN_W-1:0] s_vppn,
  input  logic              s_va_bit12,
  input  logic [ASID_W-1:0] s_asid,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn,
  output logic              match,
  output logic              odd,
  output logic              inv_sel
);

  logic big_page;
  logic s_va_hit;
  logic i_va_hit;
  logic i_asid_hit;

  assign big_page   = is_2m(key.ps);
  assign s_va_hit   = big_page ? (key.vppn[18:9] == s_vppn[18:9]) : (key.vppn == s_vppn);
  assign i_va_hit   = big_page ? (key.vppn[18:9] == inv_vppn[18:9]) : (key.vppn == inv_vppn);
  assign i_asid_hit = (key.asid == inv_asid);

  assign match = key.e & (key.g | (key.asid == s_asid)) & s_va_hit;
  // 2MB pages split on VA[21], which is vppn bit 8.
  assign odd   = big_page ? s_vppn[8] : s_va_bit12;

  // Decode the INVTLB op into this entry's clear select.
  always_comb begin
    inv_sel = 1'b0;
    unique case (inv_op)
      INV_ALL0, INV_ALL1: inv_sel = 1'b1;
      INV_GLB:            inv_sel = key.g;
      INV_NGLB:           inv_sel = ~key.g;
      INV_ASID:           inv_sel = ~key.g & i_asid_hit;
      INV_ASID_VA:        inv_sel = ~key.g & i_asid_hit & i_va_hit;
      INV_G_ASID_VA:      inv_sel = (key.g | i_asid_hit) & i_va_hit;
      default:            inv_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_match_array.sv
// 16-entry TLB storage with registered search, read, write and INVTLB.
// Optional macro TLB_MULTIHIT_CHECK_EN builds the pairwise multi-hit detector;
// without it s_multihit is tied 0.
module tlb_match_array
  import tlb_match_array_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                s_req,
  input  logic [VPPN_W-1:0]   s_vppn,
  input  logic                s_va_bit12,
  input  logic [ASID_W-1:0]   s_asid,
  output logic                s_resp_valid,
  output logic [TLBNUM-1:0]   s_match,
  output logic [TLBNUM-1:0]   s_odd,
  output logic                s_multihit,
  input  logic                we,
  input  logic [TLBIDXW-1:0]  w_index,
  input  logic [ENTRY_W-1:0]  w_entry,
  input  logic [TLBIDXW-1:0]  r_index,
  output logic [ENTRY_W-1:0]  r_entry,
  input  logic                inv_valid,
  input  logic [4:0]          inv_op,
  input  logic [ASID_W-1:0]   inv_asid,
  input  logic [VPPN_W-1:0]   inv_vppn,
  output logic                inv_err,
  output logic [TLBIDXW-1:0]  fill_index
);

  logic [ENTRY_W-1:0] entries [TLBNUM];
  logic [TLBNUM-1:0]  match_c;
  logic [TLBNUM-1:0]  odd_c;
  logic [TLBNUM-1:0]  inv_sel;

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_cmp
    tlb_entry_cmp u_cmp (
      .key        (tlb_key_t'(entries[gi][E_BIT -: KEY_W])),
      .s_vppn     (s_vppn),
      .s_va_bit12 (s_va_bit12),
      .s_asid     (s_asid),
      .inv_op     (inv_op),
      .inv_asid   (inv_asid),
      .inv_vppn   (inv_vppn),
      .match      (match_c[gi]),
      .odd        (odd_c[gi]),
      .inv_sel    (inv_sel[gi])
    );
  end

  // Entry storage: a write to w_index takes priority over an INVTLB clear of the same entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < TLBNUM; i++) entries[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (we && (w_index == TLBIDXW'(i))) begin
          entries[i] <= w_entry;
        end else if (inv_valid && inv_sel[i]) begin
          entries[i][E_BIT] <= 1'b0;
        end
      end
    end
  end

  // Search result registers; match/odd hold while no search is requested.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_resp_valid <= 1'b0;
      s_match      <= '0;
      s_odd        <= '0;
    end else begin
      s_resp_valid <= s_req;
      if (s_req) begin
        s_match <= match_c;
        s_odd   <= odd_c;
      end
    end
  end

`ifdef TLB_MULTIHIT_CHECK_EN
  logic multihit_c;

  // Any pair of simultaneous hits is a multi-hit.
  always_comb begin
    multihit_c = 1'b0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      for (int unsigned j = i + 1; j < TLBNUM; j++) begin
        multihit_c = multihit_c | (match_c[i] & match_c[j]);
      end
    end
  end

  // Multi-hit flag registered in step with s_match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_multihit <= 1'b0;
    end else if (s_req) begin
      s_multihit <= multihit_c;
    end
  end
`else
  assign s_multihit = 1'b0;
`endif

  // Read port, INVTLB error pulse and TLBFILL pseudo-random index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_entry    <= '0;
      inv_err    <= 1'b0;
      fill_index <= '0;
    end else begin
      r_entry    <= entries[r_index];
      inv_err    <= inv_valid && (inv_op > INV_G_ASID_VA);
      fill_index <= fill_index + 4'd1;
    end
  end

endmodule

// File: tb/tb_tlb_match_array.sv
// Self-checking bench for tlb_match_array: vector table plus scoreboard of search responses.
module tb_tlb_match_array;
  import tlb_match_array_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_req;
  logic [18:0]  s_vppn;
  logic         s_va_bit12;
  logic [9:0]   s_asid;
  logic         s_resp_valid;
  logic [15:0]  s_match;
  logic [15:0]  s_odd;
  logic         s_multihit;
  logic         we;
  logic [3:0]   w_index;
  logic [88:0]  w_entry;
  logic [3:0]   r_index;
  logic [88:0]  r_entry;
  logic         inv_valid;
  logic [4:0]   inv_op;
  logic [9:0]   inv_asid;
  logic [18:0]  inv_vppn;
  logic         inv_err;
  logic [3:0]   fill_index;

  always #5 clk = ~clk;

  tlb_match_array dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_req        (s_req),
    .s_vppn       (s_vppn),
    .s_va_bit12   (s_va_bit12),
    .s_asid       (s_asid),
    .s_resp_valid (s_resp_valid),
    .s_match      (s_match),
    .s_odd        (s_odd),
    .s_multihit   (s_multihit),
    .we           (we),
    .w_index      (w_index),
    .w_entry      (w_entry),
    .r_index      (r_index),
    .r_entry      (r_entry),
    .inv_valid    (inv_valid),
    .inv_op       (inv_op),
    .inv_asid     (inv_asid),
    .inv_vppn     (inv_vppn),
    .inv_err      (inv_err),
    .fill_index   (fill_index)
  );

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] o;
    logic [15:0] omask;
    logic        mh;
  } exp_t;

  typedef struct {
    logic        do_wr;
    logic [3:0]  wr_idx;
    logic [88:0] wr_entry;
    logic [18:0] vppn;
    logic        va12;
    logic [9:0]  asid;
    logic [15:0] exp_m;
    logic [15:0] exp_o;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn,
                                     input logic [5:0] ps, input logic g, input logic [9:0] asid);
    return {e, vppn, ps, g, asid, 20'hABCDE, 2'd3, 2'd1, 1'b1, 1'b1,
            20'h13579, 2'd0, 2'd2, 1'b0, 1'b1};
  endfunction

  function automatic logic mh_of(input logic [15:0] m);
`ifdef TLB_MULTIHIT_CHECK_EN
    return $countones(m) > 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [88:0] act, input logic [88:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expected search result.
  always @(negedge clk) begin
    if (resetn === 1'b1 && s_resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stale_resp: got s_resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("s_match", s_match, e.m);
        check("s_odd", s_odd & e.omask, e.o & e.omask);
        check("s_multihit", s_multihit, e.mh);
      end
    end
  end

  task automatic clr();
    s_req = 1'b0; we = 1'b0; inv_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk); clr();
  endtask

  task automatic wr(input logic [3:0] idx, input logic [88:0] ent);
    @(negedge clk); clr();
    we = 1'b1; w_index = idx; w_entry = ent;
  endtask

  task automatic srch(input logic [18:0] vppn, input logic va12, input logic [9:0] asid,
                      input logic [15:0] exp_m, input logic [15:0] exp_o,
                      input logic [15:0] omask);
    @(negedge clk); clr();
    s_req = 1'b1; s_vppn = vppn; s_va_bit12 = va12; s_asid = asid;
    sb_q.push_back('{m: exp_m, o: exp_o, omask: omask, mh: mh_of(exp_m)});
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    @(negedge clk); clr();
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd3, mk(1'b1, 19'h12345, PS_4K, 1'b0, 10'h05),
                19'h12345, 1'b1, 10'h05, 16'h0008, 16'hFFFF};
    vecs[1] = '{1'b0, 4'd0, '0, 19'h12345, 1'b0, 10'h06, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 4'd0, '0, 19'h12344, 1'b1, 10'h05, 16'h0000, 16'hFFFF};
    vecs[3] = '{1'b1, 4'd3, mk(1'b1, 19'h12345, PS_4K, 1'b1, 10'h05),
                19'h12345, 1'b0, 10'h06, 16'h0008, 16'h0000};
    vecs[4] = '{1'b1, 4'd7, mk(1'b1, 19'h12200, PS_2M, 1'b0, 10'h05),
                19'h123FF, 1'b0, 10'h05, 16'h0080, 16'h0080};
    vecs[5] = '{1'b0, 4'd0, '0, 19'h12045, 1'b1, 10'h05, 16'h0000, 16'hFF7F};
    vecs[6] = '{1'b0, 4'd0, '0, 19'h12345, 1'b1, 10'h09, 16'h0008, 16'hFFFF};
    vecs[7] = '{1'b0, 4'd0, '0, 19'h12345, 1'b0, 10'h05, 16'h0088, 16'h0080};

    clr();
    resetn = 1'b0;
    w_index = '0; w_entry = '0; r_index = '0;
    s_vppn = '0; s_va_bit12 = 1'b0; s_asid = '0;
    inv_op = '0; inv_asid = '0; inv_vppn = '0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", s_resp_valid, 0);
    check("rst_match", s_match, 0);
    check("rst_odd", s_odd, 0);
    check("rst_r_entry", r_entry, 0);
    check("rst_inv_err", inv_err, 0);
    check("rst_fill_index", fill_index, 0);

    resetn = 1'b1;
    check("fill_index_0", fill_index, 0);
    repeat (5) @(negedge clk);
    check("fill_index_5", fill_index, 5);

    // Known baseline: all entries invalid 4KB pages.
    for (int i = 0; i < 16; i++) wr(4'(i), mk(1'b0, 19'h0, PS_4K, 1'b0, 10'h0));

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wr_idx, vecs[i].wr_entry);
      srch(vecs[i].vppn, vecs[i].va12, vecs[i].asid, vecs[i].exp_m, vecs[i].exp_o, 16'hFFFF);
    end
    idle();
    idle();
    check("s_match_hold", s_match, 16'h0088);

    // Search in the same cycle as a write to idx3 sees the old contents.
    @(negedge clk); clr();
    s_req = 1'b1; s_vppn = 19'h12345; s_va_bit12 = 1'b0; s_asid = 10'h05;
    we = 1'b1; w_index = 4'd3; w_entry = mk(1'b0, 19'h12345, PS_4K, 1'b1, 10'h05);
    r_index = 4'd3;
    sb_q.push_back('{m: 16'h0088, o: 16'h0080, omask: 16'hFFFF, mh: mh_of(16'h0088)});
    srch(19'h12345, 1'b0, 10'h05, 16'h0080, 16'h0080, 16'hFFFF);
    check("read_pre_write", r_entry, mk(1'b1, 19'h12345, PS_4K, 1'b1, 10'h05));
    idle();
    check("read_idx3", r_entry, mk(1'b0, 19'h12345, PS_4K, 1'b1, 10'h05));

    // INVTLB op 4 clears every non-global entry of ASID 1.
    for (int i = 0; i < 16; i++) wr(4'(i), mk(1'b1, 19'h100 + 19'(i), PS_4K, 1'b0, 10'h01));
    srch(19'h105, 1'b0, 10'h01, 16'h0020, 16'h0000, 16'hFFFF);
    inv(5'd4, 10'h01, 19'h0);
    idle();
    check("inv_err_op4", inv_err, 0);
    for (int i = 0; i < 16; i += 5) srch(19'h100 + 19'(i), 1'b0, 10'h01, 16'h0, 16'h0, 16'hFFFF);

    // Illegal op: error pulse, entries untouched.
    for (int i = 0; i < 16; i++) wr(4'(i), mk(1'b1, 19'h100 + 19'(i), PS_4K, 1'b0, 10'h01));
    inv(5'd9, 10'h01, 19'h0);
    idle();
    check("inv_err_pulse", inv_err, 1);
    idle();
    check("inv_err_clear", inv_err, 0);
    srch(19'h10A, 1'b0, 10'h01, 16'h0400, 16'h0000, 16'hFFFF);

    // Write and INVTLB-all together: only the written entry survives.
    @(negedge clk); clr();
    we = 1'b1; w_index = 4'd2; w_entry = mk(1'b1, 19'h200, PS_4K, 1'b0, 10'h01);
    inv_valid = 1'b1; inv_op = 5'd0;
    r_index = 4'd2;
    srch(19'h200, 1'b0, 10'h01, 16'h0004, 16'h0000, 16'hFFFF);
    srch(19'h10A, 1'b0, 10'h01, 16'h0000, 16'h0000, 16'hFFFF);
    srch(19'h102, 1'b0, 10'h01, 16'h0000, 16'h0000, 16'hFFFF);
    idle();
    check("read_idx2", r_entry, mk(1'b1, 19'h200, PS_4K, 1'b0, 10'h01));

    // Duplicate entries produce two hits.
    wr(4'd0, mk(1'b1, 19'h300, PS_4K, 1'b0, 10'h01));
    wr(4'd1, mk(1'b1, 19'h300, PS_4K, 1'b0, 10'h01));
    srch(19'h300, 1'b1, 10'h01, 16'h0003, 16'hFFFF, 16'hFFFF);
    idle();
    idle();

    // Reset lands while a response is valid; nothing stale may follow.
    @(negedge clk); clr();
    s_req = 1'b1; s_vppn = 19'h300; s_va_bit12 = 1'b0; s_asid = 10'h01;
    @(posedge clk);
    #2;
    check("resp_before_reset", s_resp_valid, 1);
    resetn = 1'b0;
    #1;
    check("resp_dropped_on_reset", s_resp_valid, 0);
    check("match_cleared_on_reset", s_match, 0);
    clr();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) idle();
    srch(19'h300, 1'b0, 10'h01, 16'h0000, 16'h0000, 16'h0000);
    idle();
    idle();
    check("scoreboard_drained", 89'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_match_array.md
Name: tlb_match_array

Overview:
- 16-entry LoongArch TLB storage array with a registered search port, a read port, a write port and an INVTLB engine.
- Produces the one-hot match vector consumed directly downstream by the 16-to-4 encoder and the one-hot checker in the MMU address-translation stage.
- Holds no translation-mux logic; downstream uses the encoded index to select the entry fields.

Parameters:
- TLBNUM, 16, number of entries (fixed at 16 for encoder compatibility)
- TLBIDXW, 4, index width, log2(TLBNUM)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- s_req  in  1  search request strobe
- s_vppn  in  19  VA[31:13] to search
- s_va_bit12  in  1  VA[12], odd/even page select for 4KB pages
- s_asid  in  10  current ASID
- s_resp_valid  out  1  search result valid, one cycle after s_req
- s_match  out  16  registered one-hot match vector
- s_odd  out  16  per-entry odd-page select (VA[12] or VA[21] per entry ps)
- we  in  1  write enable
- w_index  in  4  entry to write
- w_entry  in  89  packed entry {e, vppn19, ps6, g, asid10, ppn0 20, plv0 2, mat0 2, d0, v0, ppn1 20, plv1 2, mat1 2, d1, v1}
- r_index  in  4  entry to read
- r_entry  out  89  registered read data for r_index
- inv_valid  in  1  INVTLB request
- inv_op  in  5  INVTLB op code
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA[31:13] operand
- inv_err  out  1  registered pulse: inv_op > 6
- fill_index  out  4  pseudo-random index for TLBFILL

Behaviour:
- Reset: all E bits 0; s_resp_valid, s_match, s_odd, r_entry, inv_err and fill_index all 0. Other entry fields are don't-care.
- Search: on the s_req rising edge, s_match[i] is registered as e[i] & (g[i] | asid[i]==s_asid) & VA match.
  - VA match: ps==12 compares all 19 bits; ps==21 compares vppn[18:9] only.
  - s_odd[i] = (ps==21) ? s_vppn[8] : s_va_bit12.
  - s_resp_valid = registered s_req. Latency is 1 cycle; one search per cycle is accepted back-to-back.
  - Without s_req, s_match and s_odd hold their values.
- Write: on a clk edge with we=1, entry[w_index] := w_entry.
- Read: r_entry is registered entry[r_index] every cycle, latency 1.
- Search, read or INVTLB in the same cycle as a write observes pre-write contents; the write is visible the next cycle.
- INVTLB takes one cycle and clears E for every selected entry:
  - op 0, 1: all entries
  - op 2: g=1
  - op 3: g=0
  - op 4: g=0 & asid match
  - op 5: g=0 & asid match & VA match
  - op 6: (g=1 | asid match) & VA match
  - op >6: no entry changes; inv_err pulses high for 1 cycle.
- INVTLB and write in the same cycle: the write wins on w_index; INVTLB applies to all other entries.
- fill_index: 4-bit free-running counter, +1 every cycle, wraps 15 to 0. Reset value is 0.
- Reset asserted mid-search: s_resp_valid drops immediately and no stale response is produced afterward.

Optional Feature:
- Macro: TLB_MULTIHIT_CHECK_EN.
- Defined: adds output s_multihit, registered alongside s_match. It is 1 when more than one match bit is set, computed from the pairwise AND of all 120 match pairs.
- Undefined: s_multihit exists and is tied 0; the pairwise logic is not built.

Decomposition:
- Shared package holds:
  - entry field offsets and widths, and the 89-bit entry width
  - PS_4K=12 and PS_2M=21
  - INVTLB op code constants 0 to 6
- Sub-module tlb_entry_cmp: one entry's search match, odd select and INVTLB select, instantiated 16 times via generate.

Test Plan:
- Write idx3 {e=1, vppn=0x12345, ps=12, g=0, asid=0x05}, search vppn=0x12345 asid=0x05 va12=1 -> next cycle s_match=0x0008, s_odd[3]=1, s_resp_valid=1.
- Same search with asid=0x06 -> s_match=0x0000; rewrite idx3 with g=1 -> s_match=0x0008.
- Write idx7 ps=21, vppn=0x12200, then search vppn=0x123FF -> s_match bit7=1, s_odd[7]=s_vppn[8]=1.
- Fill all 16 entries with asid=0x01, g=0, then inv_op=4 with inv_asid=0x01 -> every search misses; inv_op=9 -> inv_err pulses for one cycle and no entry changes.
- Same cycle: we on idx2 plus inv_op=0 -> only idx2 remains valid; r_index=2 reads back w_entry.
- Multihit (macro defined): identical entries in idx0 and idx1, search them -> s_match=0x0003, s_multihit=1. Also: fill_index reads 0 after reset, then 5 at cycle 5.
